// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues icache reads, retries
// refill-only completions, drops responses made stale by redirects, and buffers words for decode.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ic_valid,
  output logic [5:0]  ic_index,
  output logic [22:0] ic_tag,
  output logic [2:0]  ic_offset,
  input  logic        ic_addr_ok,
  input  logic        ic_data_ok,
  input  logic [31:0] ic_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_WAIT,
    S_DROP
  } state_t;

  state_t        state_reg, state_next;
  logic [63:0]   pc_reg, pc_next;
  logic [63:0]   req_pc_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [63:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_inst [DEPTH];
  logic          push, pop, flush;

  // The icache indexes with the live address during refill, so it always follows req_pc.
  assign ic_index   = req_pc_reg[8:3];
  assign ic_tag     = req_pc_reg[31:9];
  assign ic_offset  = {req_pc_reg[2], 2'b00};

  assign inst_valid = (count_reg != '0);
  assign inst       = mem_inst[rd_ptr_reg];
  assign inst_pc    = mem_pc[rd_ptr_reg];

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ic_valid   = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    case (state_reg)
      S_RESET: state_next = S_FETCH;
      S_FETCH: begin
        ic_valid = (count_reg < DEPTH_C);
        if (ic_valid && ic_addr_ok)
          state_next = redirect_valid ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        // A bare addr_ok here re-accepts the held request, so staying put is the retry.
        ic_valid = 1'b1;
        if (ic_data_ok) begin
          state_next = S_FETCH;
          push       = !redirect_valid;
          pc_next    = req_pc_reg + 64'd4;
        end else if (redirect_valid) begin
          state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (ic_data_ok || ic_addr_ok)
          state_next = S_FETCH;
      end
      default: state_next = S_RESET;
    endcase
    if (redirect_valid && (state_reg != S_RESET)) begin
      flush   = 1'b1;
      pc_next = redirect_pc & ~64'h3;
    end
  end

  assign pop = inst_valid && inst_ready && !flush;

  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_RESET;
      pc_reg     <= RESET_PC;
      req_pc_reg <= RESET_PC;
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      count_reg <= count_next;
      // Entering or staying in FETCH always presents the current fetch PC.
      if (state_next == S_FETCH)
        req_pc_reg <= pc_next;
      if (flush) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
      end else begin
        if (push)
          wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (pop)
          rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
      end
    end else if (push) begin
      mem_pc[wr_ptr_reg]   <= req_pc_reg;
      mem_inst[wr_ptr_reg] <= ic_rdata;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: behavioural icache responder, directed timing scenarios,
// and a randomized run scored against the sequential-program-since-last-redirect model.
module tb_ifu_fetch;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        ic_valid;
  logic [5:0]  ic_index;
  logic [22:0] ic_tag;
  logic [2:0]  ic_offset;
  logic        ic_addr_ok;
  logic        ic_data_ok;
  logic [31:0] ic_rdata;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ic_valid(ic_valid), .ic_index(ic_index), .ic_tag(ic_tag), .ic_offset(ic_offset),
    .ic_addr_ok(ic_addr_ok), .ic_data_ok(ic_data_ok), .ic_rdata(ic_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  wire [31:0] ic_addr = {ic_tag, ic_index, ic_offset};

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Icache responder: IDLE accepts, LOOKUP returns data on a hit, a miss walks MISS/REPLACE
  // back to IDLE without data, and the access right after a refill always hits.
  typedef enum {IC_IDLE, IC_LOOKUP, IC_MISS, IC_REPLACE} ic_st_t;
  ic_st_t      ic_st = IC_IDLE;
  logic [31:0] lat_addr = '0;
  logic        lat_hit = 1'b0;
  logic        just_filled = 1'b0;
  logic [31:0] miss_addr = 32'hFFFF_FFFF;
  int unsigned miss_pct = 0;
  int          cyc = 0;
  int          acc_cyc_q[$];
  logic [31:0] acc_addr_q[$];

  assign ic_addr_ok = (ic_st == IC_IDLE);
  assign ic_data_ok = (ic_st == IC_LOOKUP) && lat_hit;
  assign ic_rdata   = ic_data_ok ? word_at(lat_addr) : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    case (ic_st)
      IC_IDLE: if (ic_valid) begin
        acc_cyc_q.push_back(cyc);
        acc_addr_q.push_back(ic_addr);
        lat_addr <= ic_addr;
        if (just_filled)
          lat_hit <= 1'b1;
        else if (ic_addr == miss_addr || $urandom_range(99) < miss_pct)
          lat_hit <= 1'b0;
        else
          lat_hit <= 1'b1;
        just_filled <= 1'b0;
        ic_st <= IC_LOOKUP;
      end
      IC_LOOKUP:  ic_st <= lat_hit ? IC_IDLE : IC_MISS;
      IC_MISS:    ic_st <= IC_REPLACE;
      IC_REPLACE: begin
        ic_st <= IC_IDLE;
        just_filled <= 1'b1;
      end
      default: ic_st <= IC_IDLE;
    endcase
  end

  logic [63:0] pop_pc_q[$];
  logic [31:0] pop_inst_q[$];
  int          pop_cyc_q[$];
  int          checks = 0;
  int          errors = 0;

  // Called at a negedge once inputs are set: logs the transfer taken at the next posedge.
  task automatic tick();
    if (inst_valid && inst_ready && !redirect_valid) begin
      pop_pc_q.push_back(inst_pc);
      pop_inst_q.push_back(inst);
      pop_cyc_q.push_back(cyc);
      $display("cycle %0d pop pc=%h inst=%h", cyc, inst_pc, inst);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_logs();
    pop_pc_q.delete();
    pop_inst_q.delete();
    pop_cyc_q.delete();
    acc_cyc_q.delete();
    acc_addr_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    repeat (6) @(negedge clk);
    clear_logs();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rp;
    rp = RESET_PC[31:0];
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ic_valid !== 1'b0) begin errors++; $display("FAIL reset_ic_valid: got %b expected 0", ic_valid); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", inst); end
    checks++; if (inst_pc !== 64'h0) begin errors++; $display("FAIL reset_inst_pc: got %h expected 0", inst_pc); end
    checks++; if (ic_addr !== rp) begin errors++; $display("FAIL reset_addr: got %h expected %h", ic_addr, rp); end
    clear_logs();
    rst = 1'b1;
    tick();
    checks++; if (ic_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b expected 1", ic_valid); end
    checks++; if (ic_addr !== rp) begin errors++; $display("FAIL first_req_addr: got %h expected %h", ic_addr, rp); end
  endtask

  task automatic test_hits();
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (pop_pc_q.size() < 3 || acc_cyc_q.size() < 3) begin
      errors++;
      $display("FAIL hits_progress: got %0d pops %0d accepts expected at least 3 each", pop_pc_q.size(), acc_cyc_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pop_pc_q[i] !== RESET_PC + 64'(4 * i)) begin
          errors++; $display("FAIL hits_pc%0d: got %h expected %h", i, pop_pc_q[i], RESET_PC + 64'(4 * i));
        end
        checks++;
        if (pop_inst_q[i] !== word_at(RESET_PC[31:0] + 32'(4 * i))) begin
          errors++; $display("FAIL hits_inst%0d: got %h expected %h", i, pop_inst_q[i], word_at(RESET_PC[31:0] + 32'(4 * i)));
        end
      end
      checks++; if (acc_cyc_q[1] - acc_cyc_q[0] != 2) begin errors++; $display("FAIL hits_spacing01: got %0d expected 2", acc_cyc_q[1] - acc_cyc_q[0]); end
      checks++; if (acc_cyc_q[2] - acc_cyc_q[1] != 2) begin errors++; $display("FAIL hits_spacing12: got %0d expected 2", acc_cyc_q[2] - acc_cyc_q[1]); end
      checks++; if (pop_cyc_q[0] - acc_cyc_q[0] != 2) begin errors++; $display("FAIL hits_latency: got %0d expected 2", pop_cyc_q[0] - acc_cyc_q[0]); end
    end
  endtask

  task automatic test_miss();
    int n_acc, first_acc, second_acc, n_pop, pop_at, bad_seq;
    do_reset();
    miss_addr = 32'h8000_0040;
    inst_ready = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    miss_addr = 32'hFFFF_FFFF;
    n_acc = 0; first_acc = -1; second_acc = -1; n_pop = 0; pop_at = -1; bad_seq = 0;
    for (int i = 0; i < acc_addr_q.size(); i++)
      if (acc_addr_q[i] == 32'h8000_0040) begin
        if (n_acc == 0) first_acc = acc_cyc_q[i]; else second_acc = acc_cyc_q[i];
        n_acc++;
      end
    for (int i = 0; i < pop_pc_q.size(); i++) begin
      if (pop_pc_q[i] == 64'h8000_0040) begin n_pop++; pop_at = pop_cyc_q[i]; end
      if (pop_pc_q[i] != RESET_PC + 64'(4 * i)) bad_seq++;
    end
    checks++; if (n_acc != 2) begin errors++; $display("FAIL miss_accepts: got %0d expected 2", n_acc); end
    checks++; if (second_acc - first_acc != 4) begin errors++; $display("FAIL miss_retry_delay: got %0d expected 4", second_acc - first_acc); end
    checks++; if (n_pop != 1) begin errors++; $display("FAIL miss_pop_count: got %0d expected 1", n_pop); end
    checks++; if (pop_at - first_acc != 6) begin errors++; $display("FAIL miss_pop_delay: got %0d expected 6", pop_at - first_acc); end
    checks++; if (bad_seq != 0 || pop_pc_q.size() < 18) begin errors++; $display("FAIL miss_sequence: got %0d bad of %0d pops expected 0 bad of >=18", bad_seq, pop_pc_q.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (acc_cyc_q.size() != 2) begin errors++; $display("FAIL bp_accepts: got %0d expected 2", acc_cyc_q.size()); end
    checks++; if (ic_valid !== 1'b0) begin errors++; $display("FAIL bp_full_valid: got %b expected 0", ic_valid); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== RESET_PC) begin errors++; $display("FAIL bp_head: got %b/%h expected 1/%h", inst_valid, inst_pc, RESET_PC); end
    inst_ready = 1'b1;
    tick();
    checks++; if (ic_valid !== 1'b1 || ic_addr !== 32'h8000_0008) begin errors++; $display("FAIL bp_resume: got %b/%h expected 1/80000008", ic_valid, ic_addr); end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (pop_pc_q.size() < 3) begin
      errors++; $display("FAIL bp_pops: got %0d expected at least 3", pop_pc_q.size());
    end else if (pop_pc_q[0] !== RESET_PC || pop_pc_q[1] !== RESET_PC + 64'd4 || pop_pc_q[2] !== RESET_PC + 64'd8) begin
      errors++; $display("FAIL bp_order: got %h %h %h expected %h %h %h", pop_pc_q[0], pop_pc_q[1], pop_pc_q[2],
                         RESET_PC, RESET_PC + 64'd4, RESET_PC + 64'd8);
    end
  endtask

  task automatic test_redirect_miss();
    logic [5:0] saved_index;
    int         k, n_before, stale;
    do_reset();
    miss_addr = 32'h8000_0008;
    inst_ready = 1'b1;
    k = 0;
    while (!(acc_addr_q.size() > 0 && acc_addr_q[acc_addr_q.size() - 1] == 32'h8000_0008) && k < 30) begin
      tick(); k++;
    end
    checks++; if (k >= 30) begin errors++; $display("FAIL rdm_wait_accept: got timeout expected accept of 80000008"); end
    saved_index = ic_index;
    n_before = pop_pc_q.size();
    redirect_valid = 1'b1;
    redirect_pc = 64'h0000_0000_8000_1003;
    tick();
    redirect_valid = 1'b0;
    miss_addr = 32'hFFFF_FFFF;
    k = 0;
    while (!ic_addr_ok && k < 10) begin
      checks++; if (ic_valid !== 1'b0) begin errors++; $display("FAIL rdm_drop_valid: got %b expected 0", ic_valid); end
      checks++; if (ic_index !== saved_index) begin errors++; $display("FAIL rdm_drop_index: got %h expected %h", ic_index, saved_index); end
      tick(); k++;
    end
    checks++; if (k != 2) begin errors++; $display("FAIL rdm_drop_len: got %0d expected 2", k); end
    checks++; if (ic_valid !== 1'b0) begin errors++; $display("FAIL rdm_drop_exit_valid: got %b expected 0", ic_valid); end
    tick();
    checks++; if (ic_valid !== 1'b1 || ic_addr !== 32'h8000_1000) begin errors++; $display("FAIL rdm_target: got %b/%h expected 1/80001000", ic_valid, ic_addr); end
    for (int i = 0; i < 8; i++) tick();
    stale = 0;
    foreach (pop_pc_q[i]) if (pop_pc_q[i] == 64'h8000_0008) stale++;
    checks++; if (stale != 0) begin errors++; $display("FAIL rdm_stale: got %0d stale pops expected 0", stale); end
    checks++;
    if (pop_pc_q.size() <= n_before || pop_pc_q[n_before] !== 64'h8000_1000) begin
      errors++; $display("FAIL rdm_first_pop: got %0d pops after redirect expected first at 80001000", pop_pc_q.size() - n_before);
    end
  endtask

  task automatic test_redirect_data_ok();
    logic [63:0] tgt;
    int          k, n_before;
    do_reset();
    inst_ready = 1'b0;
    k = 0;
    while (acc_cyc_q.size() < 2 && k < 20) begin tick(); k++; end
    checks++; if (inst_valid !== 1'b1 || ic_data_ok !== 1'b1) begin errors++; $display("FAIL rdd_setup: got inst_valid=%b data_ok=%b expected 1/1", inst_valid, ic_data_ok); end
    tgt = 64'h0000_0000_8000_2000 | 64'($urandom_range(0, 1023));
    redirect_valid = 1'b1;
    redirect_pc = tgt;
    tgt = tgt & ~64'h3;
    tick();
    redirect_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdd_flush: got %b expected 0", inst_valid); end
    checks++; if (ic_valid !== 1'b1 || ic_addr !== tgt[31:0]) begin errors++; $display("FAIL rdd_target: got %b/%h expected 1/%h", ic_valid, ic_addr, tgt[31:0]); end
    inst_ready = 1'b1;
    n_before = pop_pc_q.size();
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (pop_pc_q.size() <= n_before || pop_pc_q[n_before] !== tgt) begin
      errors++; $display("FAIL rdd_first_pop: got %0d pops expected first at %h", pop_pc_q.size() - n_before, tgt);
    end
  endtask

  task automatic test_async_reset();
    int k, n_before;
    do_reset();
    inst_ready = 1'b0;
    k = 0;
    while (acc_cyc_q.size() < 2 && k < 20) begin tick(); k++; end
    rst = 1'b0;
    #1;
    checks++; if (ic_valid !== 1'b0) begin errors++; $display("FAIL areset_ic_valid: got %b expected 0", ic_valid); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL areset_inst_valid: got %b expected 0", inst_valid); end
    checks++; if (inst !== 32'h0 || inst_pc !== 64'h0) begin errors++; $display("FAIL areset_head: got %h/%h expected 0/0", inst, inst_pc); end
    #1;
    rst = 1'b1;
    tick();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL areset_no_push: got %b expected 0", inst_valid); end
    checks++; if (ic_valid !== 1'b1 || ic_addr !== RESET_PC[31:0]) begin errors++; $display("FAIL areset_refetch: got %b/%h expected 1/%h", ic_valid, ic_addr, RESET_PC[31:0]); end
    inst_ready = 1'b1;
    n_before = pop_pc_q.size();
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (pop_pc_q.size() <= n_before || pop_pc_q[n_before] !== RESET_PC) begin
      errors++; $display("FAIL areset_first_pop: got %0d pops expected first at %h", pop_pc_q.size() - n_before, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic [63:0] exp_pc;
    logic [31:0] hi, lo;
    int          npop;
    do_reset();
    miss_pct = 25;
    tick();
    exp_pc = RESET_PC;
    npop = 0;
    for (int i = 0; i < 3000; i++) begin
      inst_ready = ($urandom_range(3) != 0);
      if ($urandom_range(99) < 4) begin
        hi = $urandom;
        lo = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
        redirect_valid = 1'b1;
        redirect_pc = {hi, lo};
      end else begin
        redirect_valid = 1'b0;
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        checks++;
        if (inst_pc !== exp_pc) begin errors++; $display("FAIL rand_pc: got %h expected %h", inst_pc, exp_pc); end
        checks++;
        if (inst !== word_at(exp_pc[31:0])) begin errors++; $display("FAIL rand_inst: got %h expected %h", inst, word_at(exp_pc[31:0])); end
        exp_pc = exp_pc + 64'd4;
        npop++;
      end
      if (redirect_valid) exp_pc = redirect_pc & ~64'h3;
      tick();
    end
    redirect_valid = 1'b0;
    miss_pct = 0;
    checks++; if (npop < 200) begin errors++; $display("FAIL rand_progress: got %0d pops expected at least 200", npop); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_hits();
    test_miss();
    test_backpressure();
    test_redirect_miss();
    test_redirect_data_ok();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
